fetch_prefetch_queue: RTL and testbench

Instruction-fetch front end for the 5-stage pipeline. It owns the fetch PC, issues word reads to a variable-latency instruction memory through a req/ack handshake, and buffers returned words with their PC+1 in a small FIFO. Decode drains the FIFO; taken branches and jumps redirect it, and stalls hold it. It replaces the combinational PC → InstMem path in front of the fetch/decode register, and its outputs feed the instruction and PC+1 inputs of that register.

---
 rtl/fetch_prefetch_queue_pkg.sv | 17 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_prefetch_queue.sv | 129 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared definitions for the fetch prefetch queue: FSM encoding, defaults and
// the queue-entry layout {instr, pc_p1}.
package fetch_prefetch_queue_pkg;

  localparam int unsigned WL_DEF       = 32;
  localparam int unsigned RESET_PC_DEF = 0;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT    = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  typedef struct packed {
    logic [WL_DEF-1:0] instr;
    logic [WL_DEF-1:0] pc_p1;
  } qentry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc_p1} entries; clear has
// priority over push/pop, and push+pop at full is legal.
module fetch_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clear,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [WIDTH-1:0]           i_wdata,
  output logic [WIDTH-1:0]           o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_empty,
  output logic                       o_full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [CW-1:0]    r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + AW'(1);
      if (i_pop)  r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_push && !i_pop && !i_clear && o_full));

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(i_pop && !i_clear && o_empty));

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues req/ack word reads
// and queues {instr, pc+1} for decode. Redirects flush, stalls hold the head.
module fetch_prefetch_queue
  import fetch_prefetch_queue_pkg::*;
#(
  parameter int unsigned   WL       = WL_DEF,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [WL-1:0] RESET_PC = WL'(RESET_PC_DEF)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          stall,
  input  logic          redirect,
  input  logic [WL-1:0] redirect_pc,
  output logic          imem_req,
  output logic [WL-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [WL-1:0] imem_rdata,
  output logic          instr_valid,
  output logic [WL-1:0] instr,
  output logic [WL-1:0] pc_p1
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [1:0]      r_state;
  logic            r_req;
  logic [WL-1:0]   r_addr;
  logic [WL-1:0]   r_fetch_pc;

  logic [1:0]      w_state_nx;
  logic            w_req_nx;
  logic [WL-1:0]   w_addr_nx;
  logic [WL-1:0]   w_fetch_pc_nx;

  logic [WL-1:0]   w_addr_p1;
  logic            w_push;
  logic            w_pop;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_next;
  logic            w_empty;
  logic            w_full;
  logic [2*WL-1:0] w_head;

  assign w_addr_p1    = r_addr + WL'(1);
  assign w_push       = (r_state == S_WAIT) && imem_ack && !redirect;
  assign w_pop        = !w_empty && !stall && !redirect;
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);

  fetch_fifo #(
    .WIDTH (2 * WL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST),
    .i_clear (redirect),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({imem_rdata, w_addr_p1}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // A new request is only issued when the queue is guaranteed a free slot
  // for its returning word, so a push can never find the queue full.
  always_comb begin
    w_state_nx    = r_state;
    w_req_nx      = r_req;
    w_addr_nx     = r_addr;
    w_fetch_pc_nx = r_fetch_pc;
    case (r_state)
      S_IDLE: begin
        if (!redirect && !w_full) begin
          w_state_nx = S_WAIT;
          w_req_nx   = 1'b1;
          w_addr_nx  = r_fetch_pc;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_fetch_pc_nx = w_addr_p1;
          if (!redirect && (w_count_next < CW'(DEPTH))) begin
            w_req_nx  = 1'b1;
            w_addr_nx = w_addr_p1;
          end else begin
            w_state_nx = S_IDLE;
            w_req_nx   = 1'b0;
          end
        end else if (redirect) begin
          w_state_nx = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (imem_ack) begin
          w_state_nx = S_IDLE;
          w_req_nx   = 1'b0;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_req_nx   = 1'b0;
      end
    endcase
    if (redirect) w_fetch_pc_nx = redirect_pc;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state    <= w_state_nx;
      r_req      <= w_req_nx;
      r_addr     <= w_addr_nx;
      r_fetch_pc <= w_fetch_pc_nx;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign instr_valid = !w_empty;
  assign instr       = w_empty ? '0 : w_head[2*WL-1:WL];
  assign pc_p1       = w_empty ? '0 : w_head[WL-1:0];

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with a variable-latency memory model.
module tb_fetch_prefetch_queue;
  import fetch_prefetch_queue_pkg::*;

  logic        CLK;
  logic        RST;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc_p1;

  int n_checks = 0;
  int n_err    = 0;

  int unsigned lat;
  int unsigned mcnt;

  fetch_prefetch_queue #(
    .WL       (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc_p1       (pc_p1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory: acks after `lat` extra cycles of req being high, data = f(addr).
  assign imem_ack   = imem_req && (mcnt == lat);
  assign imem_rdata = 32'hC0DE_0000 + imem_addr;

  always @(posedge CLK or negedge RST) begin
    if (!RST)          mcnt <= 0;
    else if (imem_ack) mcnt <= 0;
    else if (imem_req) mcnt <= mcnt + 1;
  end

  typedef struct {
    logic        rst;
    logic        stall;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    qentry_t     exp_q;
  } vec_t;

  vec_t tbl [17];

  function automatic logic [31:0] im(input logic [31:0] a);
    return 32'hC0DE_0000 + a;
  endfunction

  function automatic vec_t mk(input logic rst, input logic st, input logic rq,
                              input logic [31:0] a, input logic v,
                              input logic [31:0] i, input logic [31:0] p);
    vec_t t;
    t.rst         = rst;
    t.stall       = st;
    t.exp_req     = rq;
    t.exp_addr    = a;
    t.exp_valid   = v;
    t.exp_q.instr = i;
    t.exp_q.pc_p1 = p;
    return t;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rq, input logic [31:0] a,
                         input logic v, input logic [31:0] i, input logic [31:0] p);
    chk({tag, ".req"},   {31'b0, imem_req},    {31'b0, rq});
    chk({tag, ".addr"},  imem_addr,            a);
    chk({tag, ".valid"}, {31'b0, instr_valid}, {31'b0, v});
    chk({tag, ".instr"}, instr,                i);
    chk({tag, ".pc_p1"}, pc_p1,                p);
  endtask

  task automatic do_reset();
    RST = 1'b0;
    step();
    RST = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int k;

    // Streaming from reset, then reset again and fill the queue under stall.
    tbl[0]  = mk(1, 0, 1, 32'd0, 0, 32'h0,  32'd0);
    tbl[1]  = mk(1, 0, 1, 32'd1, 1, im(0),  32'd1);
    tbl[2]  = mk(1, 0, 1, 32'd2, 1, im(1),  32'd2);
    tbl[3]  = mk(1, 0, 1, 32'd3, 1, im(2),  32'd3);
    tbl[4]  = mk(1, 0, 1, 32'd4, 1, im(3),  32'd4);
    tbl[5]  = mk(0, 0, 0, 32'd0, 0, 32'h0,  32'd0);
    tbl[6]  = mk(1, 1, 1, 32'd0, 0, 32'h0,  32'd0);
    tbl[7]  = mk(1, 1, 1, 32'd1, 1, im(0),  32'd1);
    tbl[8]  = mk(1, 1, 1, 32'd2, 1, im(0),  32'd1);
    tbl[9]  = mk(1, 1, 1, 32'd3, 1, im(0),  32'd1);
    tbl[10] = mk(1, 1, 0, 32'd3, 1, im(0),  32'd1);
    tbl[11] = mk(1, 1, 0, 32'd3, 1, im(0),  32'd1);
    tbl[12] = mk(1, 0, 0, 32'd3, 1, im(1),  32'd2);
    tbl[13] = mk(1, 0, 1, 32'd4, 1, im(2),  32'd3);
    tbl[14] = mk(1, 0, 1, 32'd5, 1, im(3),  32'd4);
    tbl[15] = mk(1, 0, 1, 32'd6, 1, im(4),  32'd5);
    tbl[16] = mk(1, 0, 1, 32'd7, 1, im(5),  32'd6);

    RST = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; lat = 0;
    #1 RST = 1'b0;
    #2 chk_out("reset", 0, 32'h0, 0, 32'h0, 32'h0);
    step();

    for (int i = 0; i < 17; i++) begin
      RST   = tbl[i].rst;
      stall = tbl[i].stall;
      step();
      chk_out($sformatf("row%0d", i), tbl[i].exp_req, tbl[i].exp_addr,
              tbl[i].exp_valid, tbl[i].exp_q.instr, tbl[i].exp_q.pc_p1);
    end
    RST = 1'b1; stall = 1'b0;

    // Redirect while addr 5 is outstanding with a delayed ack.
    do_reset();
    k = 0;
    do begin step(); k++; end while (!(imem_req && imem_addr == 32'd5) && k < 20);
    chk("t3.reach_addr5", imem_addr, 32'd5);
    lat = 3;
    step();                          chk_out("t3.c1", 1, 32'd5, 0, 32'h0, 32'h0);
    redirect = 1'b1; redirect_pc = 32'h40;
    step(); redirect = 1'b0;         chk_out("t3.c2", 1, 32'd5, 0, 32'h0, 32'h0);
    step();                          chk_out("t3.c3", 1, 32'd5, 0, 32'h0, 32'h0);
    step();                          chk_out("t3.c4", 0, 32'd5, 0, 32'h0, 32'h0);
    lat = 0;
    step();                          chk_out("t3.c5", 1, 32'h40, 0, 32'h0, 32'h0);
    step();                          chk_out("t3.c6", 1, 32'h41, 1, im(32'h40), 32'h41);

    // Redirect in the ack cycle of addr 5 with two entries queued.
    do_reset();
    k = 0;
    do begin step(); k++; end while (!(imem_req && imem_addr == 32'd4) && k < 20);
    chk("t4.reach_addr4", imem_addr, 32'd4);
    stall = 1'b1;
    step();                          chk_out("t4.c0", 1, 32'd5, 1, im(3), 32'd4);
    redirect = 1'b1; redirect_pc = 32'h40;
    step(); redirect = 1'b0; stall = 1'b0;
                                     chk_out("t4.c1", 0, 32'd5, 0, 32'h0, 32'h0);
    step();                          chk_out("t4.c2", 1, 32'h40, 0, 32'h0, 32'h0);
    step();                          chk_out("t4.c3", 1, 32'h41, 1, im(32'h40), 32'h41);

    // Asynchronous reset between edges while a request is outstanding.
    #3 RST = 1'b0;
    #1                               chk_out("t5.async", 0, 32'h0, 0, 32'h0, 32'h0);
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;              chk_out("t5.first", 1, 32'h0, 0, 32'h0, 32'h0);
    step();                          chk_out("t5.second", 1, 32'h1, 1, im(0), 32'h1);

    // Queue at DEPTH-1 with simultaneous push and pop.
    do_reset();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk_out("t6.fill3", 1, 32'd3, 1, im(0), 32'd1);
    stall = 1'b0;
    step();                          chk_out("t6.pp1", 1, 32'd4, 1, im(1), 32'd2);
    step();                          chk_out("t6.pp2", 1, 32'd5, 1, im(2), 32'd3);
    step();                          chk_out("t6.pp3", 1, 32'd6, 1, im(3), 32'd4);
    step();                          chk_out("t6.pp4", 1, 32'd7, 1, im(4), 32'd5);

    // pc_p1 wraps from all-ones to zero.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step(); redirect = 1'b0;         chk_out("t7.redir", 0, 32'd7, 0, 32'h0, 32'h0);
    step();                          chk_out("t7.issue", 1, 32'hFFFF_FFFF, 0, 32'h0, 32'h0);
    step();                          chk_out("t7.wrap", 1, 32'h0, 1, im(32'hFFFF_FFFF), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
